// File: rtl/spi_master_ctrl.sv
// Register-mapped single-slave SPI master on the bus2ip/ip2bus interface.
// Registers: 0 CTRL, 1 STATUS, 2 TXDATA, 3 RXDATA. One MSB-first full-duplex
// frame of DATA_W bits per START, with programmable CPOL/CPHA and SCLK divider.
module spi_master_ctrl #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic         ACLK,
  input  logic         ARESETn,
  input  logic [31:0]  bus2ip_data,
  input  logic [3:0]   bus2ip_wrce,
  input  logic [3:0]   bus2ip_rdce,
  output logic [127:0] ip2bus_data,
  output logic         ip2bus_wrack,
  output logic         ip2bus_rdack,
  output logic         spi_sclk,
  output logic         spi_mosi,
  input  logic         spi_miso,
  output logic         spi_cs_n,
  output logic         irq
);

  localparam int unsigned K_W = 7;
  localparam logic [K_W-1:0] K_LAST = K_W'(2 * DATA_W - 1);
  localparam logic [K_W-1:0] K_PRE  = K_W'(2 * DATA_W - 2);

  typedef enum logic [1:0] {ST_IDLE, ST_LEAD, ST_SHIFT, ST_TRAIL} state_t;

  state_t              state, state_nxt;
  logic [7:0]          cnt;
  logic [K_W-1:0]      k;
  logic [DATA_W-1:0]   sh_tx, sh_rx, tx_reg, rx_reg;
  logic [DATA_W:0]     rx_next;
  logic                ctrl_cpol, ctrl_cpha, done, busy;
  logic [7:0]          ctrl_div;
  logic                wr_pend, rd_pend, wr_fire, rd_fire, start_go;
  logic                tick, lead_edge, trail_edge, finish;
  logic [31:0]         ctrl_word, status_word, tx_word, rx_word;
  logic                unused_bits;

  assign wr_fire  = (|bus2ip_wrce) && !wr_pend;
  assign rd_fire  = (|bus2ip_rdce) && !rd_pend;
  assign busy     = (state != ST_IDLE);
  assign start_go = wr_fire && bus2ip_wrce[0] && bus2ip_data[0] && !busy;
  assign rx_next  = {sh_rx, spi_miso};
  assign unused_bits = ^{bus2ip_data, rx_next[DATA_W]};

  // State register
  always_ff @(posedge ACLK) begin
    if (!ARESETn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state, SCLK edge events and SPI pin outputs
  always_comb begin
    state_nxt  = state;
    tick       = (cnt == ctrl_div);
    lead_edge  = 1'b0;
    trail_edge = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE:  if (start_go) state_nxt = ST_LEAD;
      ST_LEAD:  if (tick) begin
                  state_nxt = ST_SHIFT;
                  lead_edge = 1'b1;
                end
      ST_SHIFT: if (tick) begin
                  if (k == K_LAST) state_nxt = ST_TRAIL;
                  else if (k[0])   lead_edge  = 1'b1;
                  else             trail_edge = 1'b1;
                end
      ST_TRAIL: if (tick) begin
                  state_nxt = ST_IDLE;
                  finish    = 1'b1;
                end
      default:  state_nxt = ST_IDLE;
    endcase
    spi_cs_n = (state == ST_IDLE);
    spi_sclk = ctrl_cpol ^ ((state == ST_SHIFT) && !k[0]);
    spi_mosi = (state != ST_IDLE) && sh_tx[DATA_W-1];
  end

  // Half-period timer, half-period index and the TX/RX shifters.
  // lead_edge/trail_edge fire on the ACLK edge that enters an even/odd k,
  // so MISO is sampled exactly as SCLK changes level.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      cnt   <= '0;
      k     <= '0;
      sh_tx <= '0;
      sh_rx <= '0;
    end else begin
      if (state == ST_IDLE || tick) cnt <= '0;
      else                          cnt <= cnt + 1'b1;
      if (start_go) begin
        sh_tx <= tx_reg;
        sh_rx <= '0;
        k     <= '0;
      end
      if (state == ST_SHIFT && tick) k <= k + 1'b1;
      if (lead_edge) begin
        if (ctrl_cpha) begin
          if (state == ST_SHIFT) sh_tx <= sh_tx << 1;
        end else begin
          sh_rx <= rx_next[DATA_W-1:0];
        end
      end
      if (trail_edge) begin
        if (ctrl_cpha)       sh_rx <= rx_next[DATA_W-1:0];
        else if (k != K_PRE) sh_tx <= sh_tx << 1;
      end
    end
  end

  // Register file, DONE flag and completion interrupt
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      ctrl_cpol <= 1'b0;
      ctrl_cpha <= 1'b0;
      ctrl_div  <= 8'(DEFAULT_DIV);
      tx_reg    <= '0;
      rx_reg    <= '0;
      done      <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (wr_fire && bus2ip_wrce[0] && !busy) begin
        ctrl_cpol <= bus2ip_data[1];
        ctrl_cpha <= bus2ip_data[2];
        ctrl_div  <= bus2ip_data[15:8];
      end
      if (wr_fire && bus2ip_wrce[2]) tx_reg <= bus2ip_data[DATA_W-1:0];
      if (finish) rx_reg <= sh_rx;
      // Completion takes priority over a coincident clearing read
      if (finish)                             done <= 1'b1;
      else if (start_go)                      done <= 1'b0;
      else if (rd_fire && bus2ip_rdce[3])     done <= 1'b0;
      irq <= finish;
    end
  end

  // Read-back word assembly
  always_comb begin
    ctrl_word              = '0;
    ctrl_word[1]           = ctrl_cpol;
    ctrl_word[2]           = ctrl_cpha;
    ctrl_word[15:8]        = ctrl_div;
    status_word            = '0;
    status_word[0]         = busy;
    status_word[1]         = done;
    tx_word                = '0;
    tx_word[DATA_W-1:0]    = tx_reg;
    rx_word                = '0;
    rx_word[DATA_W-1:0]    = rx_reg;
  end

  // Single-pulse acknowledges and registered read data
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wr_pend      <= 1'b0;
      rd_pend      <= 1'b0;
      ip2bus_wrack <= 1'b0;
      ip2bus_rdack <= 1'b0;
      ip2bus_data  <= '0;
    end else begin
      wr_pend      <= |bus2ip_wrce;
      rd_pend      <= |bus2ip_rdce;
      ip2bus_wrack <= wr_fire;
      ip2bus_rdack <= rd_fire;
      ip2bus_data  <= {rx_word, tx_word, status_word, ctrl_word};
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: register access, SPI modes 0 and 3,
// busy protection, DONE clearing priority and mid-transfer reset.
module tb_spi_master_ctrl;

  logic         ACLK = 1'b0;
  logic         ARESETn;
  logic [31:0]  bus2ip_data;
  logic [3:0]   bus2ip_wrce;
  logic [3:0]   bus2ip_rdce;
  logic [127:0] ip2bus_data;
  logic         ip2bus_wrack, ip2bus_rdack;
  logic         spi_sclk, spi_mosi, spi_miso, spi_cs_n, irq;

  int checks = 0;
  int errors = 0;

  // Bench-side SPI slave: loopback or a fixed pattern shifted out on SCLK falls
  logic       loop_en = 1'b1;
  logic [7:0] pat = 8'h00;
  int         falls = 0, falls_base = 0;
  int         rises = 0, cs_low = 0;
  logic [7:0] mosi_cap = 8'h00;
  logic       slave_bit;

  spi_master_ctrl #(.DATA_W(8), .DEFAULT_DIV(4)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .bus2ip_data(bus2ip_data), .bus2ip_wrce(bus2ip_wrce), .bus2ip_rdce(bus2ip_rdce),
    .ip2bus_data(ip2bus_data), .ip2bus_wrack(ip2bus_wrack), .ip2bus_rdack(ip2bus_rdack),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .spi_cs_n(spi_cs_n), .irq(irq)
  );

  always #5 ACLK = ~ACLK;

  // Slave output bit selected by the number of SCLK falls since the frame began
  always_comb begin
    int idx;
    idx = falls - falls_base;
    slave_bit = 1'b0;
    if (idx >= 1 && idx <= 8) slave_bit = pat[8 - idx];
  end
  assign spi_miso = loop_en ? spi_mosi : slave_bit;

  // Pin monitors
  always @(negedge spi_sclk) if (!spi_cs_n) falls++;
  always @(posedge spi_sclk) if (!spi_cs_n) begin
    rises++;
    mosi_cap = {mosi_cap[6:0], spi_mosi};
  end
  always @(negedge ACLK) if (!spi_cs_n) cs_low++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input int idx, input logic [31:0] d);
    int acks;
    acks = 0;
    @(negedge ACLK);
    bus2ip_data = d;
    bus2ip_wrce = 4'(1 << idx);
    for (int c = 0; c < 3; c++) begin
      @(negedge ACLK);
      if (ip2bus_wrack) acks++;
    end
    bus2ip_wrce = '0;
    @(negedge ACLK);
    if (ip2bus_wrack) acks++;
    chk("wrack_count", acks, 1);
  endtask

  task automatic bus_read(input int idx, output logic [31:0] d);
    int acks;
    acks = 0;
    d = '0;
    @(negedge ACLK);
    bus2ip_rdce = 4'(1 << idx);
    for (int c = 0; c < 3; c++) begin
      @(negedge ACLK);
      if (ip2bus_rdack) begin
        acks++;
        d = ip2bus_data[idx*32 +: 32];
      end
    end
    bus2ip_rdce = '0;
    @(negedge ACLK);
    if (ip2bus_rdack) acks++;
    chk("rdack_count", acks, 1);
  endtask

  task automatic wait_irq(input int limit);
    int c;
    logic seen;
    c = 0;
    seen = 1'b0;
    while (!seen && c < limit) begin
      @(negedge ACLK);
      seen = irq;
      c++;
    end
    chk("irq_seen", seen, 1);
  endtask

  initial begin
    logic [31:0] rd;
    int cs0, r0, irqs;

    ARESETn = 1'b0;
    bus2ip_data = '0;
    bus2ip_wrce = '0;
    bus2ip_rdce = '0;
    repeat (3) @(negedge ACLK);
    ARESETn = 1'b1;

    // Reset state
    chk("rst_cs_n", spi_cs_n, 1);
    chk("rst_sclk", spi_sclk, 0);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_irq", irq, 0);
    chk("rst_acks", {ip2bus_wrack, ip2bus_rdack}, 0);
    bus_read(0, rd);  chk("rst_ctrl", rd, 32'h0000_0400);
    bus_read(1, rd);  chk("rst_status", rd, 32'h0);
    bus_write(2, 32'h0000_00A5);
    bus_read(2, rd);  chk("tx_readback", rd, 32'hA5);

    // Mode 0, DIV=1, loopback of 0xA5
    bus_write(0, 32'h0000_0100);
    loop_en = 1'b1;
    cs0 = cs_low; r0 = rises;
    bus_write(0, 32'h0000_0101);
    wait_irq(200);
    chk("m0_cs_low", cs_low - cs0, 36);
    chk("m0_rises", rises - r0, 8);
    chk("m0_mosi_bits", mosi_cap, 8'hA5);
    bus_read(1, rd);  chk("m0_status", rd, 32'h2);
    bus_read(3, rd);  chk("m0_rxdata", rd, 32'hA5);

    // START and TXDATA writes while busy
    bus_write(2, 32'h0000_003C);
    cs0 = cs_low; irqs = 0;
    bus_write(0, 32'h0000_0101);
    bus_read(1, rd);  chk("busy_status", rd, 32'h1);
    bus_write(0, 32'h0000_0001);
    bus_write(2, 32'h0000_00FF);
    wait_irq(200);
    chk("busy_cs_low", cs_low - cs0, 36);
    chk("busy_mosi_bits", mosi_cap, 8'h3C);
    for (int c = 0; c < 60; c++) begin
      @(negedge ACLK);
      if (irq) irqs++;
    end
    chk("busy_no_restart_irq", irqs, 0);
    chk("busy_cs_idle", spi_cs_n, 1);
    bus_read(3, rd);  chk("busy_rxdata", rd, 32'h3C);
    bus_read(2, rd);  chk("busy_txdata", rd, 32'hFF);
    bus_read(0, rd);  chk("busy_ctrl_kept", rd, 32'h0000_0100);

    // Mode 3, DIV=0, slave drives 0x3C
    bus_write(0, 32'h0000_0006);
    chk("m3_sclk_idle", spi_sclk, 1);
    loop_en = 1'b0;
    pat = 8'h3C;
    falls_base = falls;
    cs0 = cs_low;
    bus_write(0, 32'h0000_0007);
    wait_irq(100);
    chk("m3_cs_low", cs_low - cs0, 18);
    chk("m3_sclk_after", spi_sclk, 1);
    bus_read(1, rd);  chk("m3_status_done", rd, 32'h2);
    bus_read(3, rd);  chk("m3_rxdata", rd, 32'h3C);
    bus_read(1, rd);  chk("done_cleared", rd, 32'h0);

    // Completion coinciding with the RXDATA read: DONE must stay set
    bus_write(0, 32'h0000_0100);
    loop_en = 1'b1;
    bus_write(2, 32'h0000_005A);
    bus_write(0, 32'h0000_0101);
    repeat (32) @(negedge ACLK);
    bus2ip_rdce = 4'b1000;
    @(negedge ACLK);
    chk("coin_irq", irq, 1);
    chk("coin_rdack", ip2bus_rdack, 1);
    chk("coin_old_rx", ip2bus_data[127:96], 32'h3C);
    repeat (2) @(negedge ACLK);
    bus2ip_rdce = '0;
    @(negedge ACLK);
    bus_read(1, rd);  chk("coin_done_kept", rd, 32'h2);
    bus_read(3, rd);  chk("coin_rxdata", rd, 32'h5A);

    // Reset during SHIFT
    bus_write(0, 32'h0000_0101);
    chk("mid_cs_low", spi_cs_n, 0);
    ARESETn = 1'b0;
    @(negedge ACLK);
    ARESETn = 1'b1;
    chk("mrst_cs_n", spi_cs_n, 1);
    chk("mrst_sclk", spi_sclk, 0);
    chk("mrst_mosi", spi_mosi, 0);
    bus_read(1, rd);  chk("mrst_status", rd, 32'h0);
    bus_read(3, rd);  chk("mrst_rxdata", rd, 32'h0);
    bus_read(0, rd);  chk("mrst_ctrl", rd, 32'h0000_0400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
